// File: rtl/secded_err_monitor.sv
// Flow-controlled stage behind the SECDED decoder: 2-entry skid buffer, saturating SEC/DED counters,
// sticky SEC threshold interrupt. Define SECDED_ERR_LOG_EN to add the first-uncorrectable-word log.
module secded_err_monitor #(
  parameter int CNT_W      = 16,
  parameter int SEC_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [71:0]      in_data,
  input  logic             in_single,
  input  logic             in_double,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_uncorr,
  output logic [CNT_W-1:0] sec_count,
  output logic [CNT_W-1:0] ded_count,
  input  logic             clr_counts,
  output logic             thresh_irq,
  input  logic             irq_ack
`ifdef SECDED_ERR_LOG_EN
  ,
  output logic             log_valid,
  output logic [71:0]      log_data
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(SEC_THRESH - 1);

  logic        skid_valid;
  logic [63:0] skid_data;
  logic        skid_uncorr;

  logic accept;
  logic out_load;
  logic sec_inc;
  logic ded_inc;
  logic irq_set;

  // in_ready comes straight from the skid flop, so there is no comb path from out_ready.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign out_load = ~out_valid | out_ready;
  assign ded_inc  = accept & in_double;
  assign sec_inc  = accept & ~in_double & in_single;
  assign irq_set  = sec_inc & ~clr_counts & (sec_count == THRESH_M1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values;
  // data registers are reset too because out_data has a defined reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_uncorr  <= 1'b0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_uncorr <= 1'b0;
    end else if (out_load) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_uncorr <= skid_uncorr;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) begin
          out_data   <= in_data[63:0];
          out_uncorr <= in_double;
        end
      end
    end else if (accept) begin
      // Output is stalled: park the new word behind it.
      skid_valid  <= 1'b1;
      skid_data   <= in_data[63:0];
      skid_uncorr <= in_double;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_count  <= '0;
      ded_count  <= '0;
      thresh_irq <= 1'b0;
    end else begin
      if (clr_counts) begin
        sec_count <= '0;
        ded_count <= '0;
      end else begin
        if (sec_inc && sec_count != CNT_MAX) sec_count <= sec_count + 1'b1;
        if (ded_inc && ded_count != CNT_MAX) ded_count <= ded_count + 1'b1;
      end
      // Only an exact hit of the threshold sets the flag, so it re-arms once the count is cleared.
      if (irq_set)      thresh_irq <= 1'b1;
      else if (irq_ack) thresh_irq <= 1'b0;
    end
  end

`ifdef SECDED_ERR_LOG_EN
  always_ff @(posedge clk) begin
    if (rst || clr_counts) begin
      log_valid <= 1'b0;
      log_data  <= '0;
    end else if (ded_inc && !log_valid) begin
      log_valid <= 1'b1;
      log_data  <= in_data;
    end
  end
`else
  logic unused_check_bits;
  assign unused_check_bits = ^in_data[71:64];
`endif

endmodule

// File: tb/tb_secded_err_monitor.sv
// Directed + randomized bench for secded_err_monitor with a payload scoreboard and a counter/irq model.
module tb_secded_err_monitor;

  localparam int CNT_W      = 4;
  localparam int SEC_THRESH = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [71:0]      in_data;
  logic             in_single;
  logic             in_double;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic             out_uncorr;
  logic [CNT_W-1:0] sec_count;
  logic [CNT_W-1:0] ded_count;
  logic             clr_counts;
  logic             thresh_irq;
  logic             irq_ack;
`ifdef SECDED_ERR_LOG_EN
  logic             log_valid;
  logic [71:0]      log_data;
`endif

  secded_err_monitor #(.CNT_W(CNT_W), .SEC_THRESH(SEC_THRESH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_single(in_single), .in_double(in_double),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_uncorr(out_uncorr),
    .sec_count(sec_count), .ded_count(ded_count), .clr_counts(clr_counts),
    .thresh_irq(thresh_irq), .irq_ack(irq_ack)
`ifdef SECDED_ERR_LOG_EN
    , .log_valid(log_valid), .log_data(log_data)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [64:0]      sb[$];
  int               occ;
  logic [CNT_W-1:0] exp_sec;
  logic [CNT_W-1:0] exp_ded;
  logic             exp_irq;
  logic             exp_lv;
  logic [71:0]      exp_ld;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [71:0] d, input logic s, input logic dbl);
    in_valid  = v;
    in_data   = d;
    in_single = s;
    in_double = dbl;
  endtask

  // One clock: check handshake/payload before the edge, advance the model, check state after it.
  task automatic tick();
    logic       acc, drn, sec_inc, ded_inc, irq_set;
    logic [64:0] front;
    @(negedge clk);
    check("in_ready", in_ready, occ < 2);
    check("out_valid", out_valid, occ > 0);
    acc = in_valid && (occ < 2);
    drn = (occ > 0) && out_ready;
    if (occ > 0) begin
      front = drn ? sb.pop_front() : sb[0];
      check("out_data", out_data, front[63:0]);
      check("out_uncorr", out_uncorr, front[64]);
    end
    if (acc) sb.push_back({in_double, in_data[63:0]});
    occ = occ + int'(acc) - int'(drn);
    sec_inc = acc && !in_double && in_single;
    ded_inc = acc && in_double;
    irq_set = sec_inc && !clr_counts && (exp_sec == CNT_W'(SEC_THRESH - 1));
    if (clr_counts) begin
      exp_sec = '0;
      exp_ded = '0;
    end else begin
      if (sec_inc && exp_sec != CNT_MAX) exp_sec = exp_sec + 1'b1;
      if (ded_inc && exp_ded != CNT_MAX) exp_ded = exp_ded + 1'b1;
    end
    if (irq_set)      exp_irq = 1'b1;
    else if (irq_ack) exp_irq = 1'b0;
    if (clr_counts) begin
      exp_lv = 1'b0;
      exp_ld = '0;
    end else if (ded_inc && !exp_lv) begin
      exp_lv = 1'b1;
      exp_ld = in_data;
    end
    @(posedge clk);
    #1;
    check("sec_count", sec_count, exp_sec);
    check("ded_count", ded_count, exp_ded);
    check("thresh_irq", thresh_irq, exp_irq);
`ifdef SECDED_ERR_LOG_EN
    check("log_valid", log_valid, exp_lv);
    check("log_data", log_data, exp_ld);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    clr_counts = 1'b0;
    irq_ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    occ = 0; exp_sec = '0; exp_ded = '0; exp_irq = 1'b0; exp_lv = 1'b0; exp_ld = '0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_out_uncorr", out_uncorr, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_sec", sec_count, '0);
    check("rst_ded", ded_count, '0);
    check("rst_irq", thresh_irq, 1'b0);
    rst = 1'b0;
  endtask

  task automatic pulse_clr();
    drive(1'b0, '0, 1'b0, 1'b0);
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
  endtask

  initial begin
    out_ready = 1'b1;
    do_reset();

    // Clean words stream through at one per cycle.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 72'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();

    // Backpressure: two words absorbed, third held off until the consumer drains.
    out_ready = 1'b0;
    drive(1'b1, 72'h10, 1'b0, 1'b0); tick();
    drive(1'b1, 72'h11, 1'b0, 1'b0); tick();
    drive(1'b1, 72'h12, 1'b0, 1'b0); tick();
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();

    // SEC threshold, then ack coincident with the 9th SEC word.
    for (int i = 0; i < SEC_THRESH; i++) begin
      drive(1'b1, 72'h100 + 72'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 72'h1FF, 1'b1, 1'b0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();

    // clr_counts does not clear a pending irq; the flag re-arms after the clear.
    pulse_clr();
    for (int i = 0; i < SEC_THRESH; i++) begin
      drive(1'b1, 72'h200 + 72'(i), 1'b1, 1'b0);
      tick();
    end
    pulse_clr();
    irq_ack = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    irq_ack = 1'b0;

    // Both flags set: DED class, uncorr payload, first logged word.
    drive(1'b1, {8'h5A, 64'hAAAA_AAAA_AAAA_AAAA}, 1'b1, 1'b1); tick();
    drive(1'b1, {8'hC3, 64'hBBBB_BBBB_BBBB_BBBB}, 1'b0, 1'b1); tick();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, {8'(i), $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
      tick();
    end
    drive(1'b1, {8'h11, 64'hDDDD_0000_0000_DDDD}, 1'b0, 1'b1);
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    drive(1'b1, {8'h22, 64'hCCCC_CCCC_CCCC_CCCC}, 1'b0, 1'b1); tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();

    // Randomized traffic with backpressure, occasional ack and clear.
    for (int i = 0; i < 60; i++) begin
      out_ready  = 1'($urandom_range(0, 2) != 0);
      irq_ack    = 1'($urandom_range(0, 9) == 0);
      clr_counts = 1'($urandom_range(0, 14) == 0);
      drive(1'($urandom_range(0, 3) != 0), {8'($urandom), $urandom, $urandom},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      tick();
    end
    irq_ack = 1'b0;
    clr_counts = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) tick();
    check("sb_empty", 72'(sb.size()), 72'h0);

    // Reset with both buffer entries full discards them.
    out_ready = 1'b0;
    drive(1'b1, 72'h31, 1'b0, 1'b0); tick();
    drive(1'b1, 72'h32, 1'b0, 1'b0); tick();
    do_reset();
    out_ready = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
